// File: rtl/tcm_port_arbiter_pkg.sv
// tcm_arb_pkg: shared types and constants for the TCM port arbiter.
// The FSM state encoding, the grant index values and the default geometry
// of the scratchpad port live here so the top, the arbiter sub-module and
// the master-side interface all agree on them.
package tcm_arb_pkg;

    // Sequencer states: accept a request, drive the SRAM for one cycle,
    // then return the response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Grant index values (also used for the last_grant register).
    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    // Default scratchpad geometry.
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_N_ENTRIES  = 1024;

endpackage : tcm_arb_pkg

// File: rtl/tcm_port_arbiter_if.sv
// tcm_port_arbiter_if: one master's request/response bundle towards the
// TCM port arbiter. A master holds req with a stable command until it sees
// a one-cycle ready; rdata is meaningful only while ready is high.
interface tcm_port_arbiter_if
    import tcm_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEFAULT_N_ENTRIES)
) ();

    logic                    req;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    ready;

    // Requesting side (core data port or DMA/boot loader).
    modport master (
        output req, we, be, addr, wdata,
        input  rdata, ready
    );

    // Arbiter side.
    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, ready
    );

endinterface : tcm_port_arbiter_if

// File: rtl/tcm_port_arbiter_rr_arb2.sv
// tcm_rr_arb2: combinational two-way winner select for the TCM port arbiter.
// Default build: round-robin, the master that was not granted last wins a
// tie, so neither side can starve.
// With TCM_ARB_FIXED_PRIO_EN defined: M0 (core) always beats M1 (DMA) and
// last_grant is ignored; M1 may starve while M0 keeps requesting.
module tcm_rr_arb2
    import tcm_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

`ifdef TCM_ARB_FIXED_PRIO_EN
    // last_grant has no meaning under fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    // Fixed priority: M1 only wins when M0 is not requesting.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = GNT_M0;
        if (!req_i[0] && req_i[1]) begin
            gnt_idx_o = GNT_M1;
        end
    end
`else
    // Round-robin: a lone requester wins, a tie goes to the non-last master.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = GNT_M0;
        unique case (req_i)
            2'b10:   gnt_idx_o = GNT_M1;
            2'b11:   gnt_idx_o = ~last_grant_i;
            default: gnt_idx_o = GNT_M0;
        endcase
    end
`endif

endmodule : tcm_rr_arb2

// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter: arbiter and sequencer for one port of the dual-port TCM
// scratchpad. Two held-valid masters (M0 core, M1 DMA/boot loader) share the
// port; one access is issued every three cycles (IDLE -> ISSUE -> WAIT).
// SRAM-side command outputs and the ready pulses are registered; read data
// is routed straight from the SRAM's registered output during WAIT and is
// forced to zero whenever the matching ready is low.
// Optional build macro: TCM_ARB_FIXED_PRIO_EN (fixed M0 priority, see
// tcm_rr_arb2). DATA_WIDTH must be a multiple of 8.
module tcm_port_arbiter
    import tcm_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int N_ENTRIES  = DEFAULT_N_ENTRIES,
    localparam int ADDR_WIDTH = $clog2(N_ENTRIES),
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    tcm_port_arbiter_if.slave     m0_if,
    tcm_port_arbiter_if.slave     m1_if,

    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [BE_WIDTH-1:0]   sram_be_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    input  logic                  sram_ready_i
);

    state_t                state_q;
    logic                  grant_q;
    logic                  last_grant_q;

    logic                  sram_en_q;
    logic                  sram_we_q;
    logic [BE_WIDTH-1:0]   sram_be_q;
    logic [ADDR_WIDTH-1:0] sram_addr_q;
    logic [DATA_WIDTH-1:0] sram_wdata_q;

    // Remembers whether the in-flight access is a write, so read data can be
    // suppressed during a write's WAIT cycle even after sram_we_o has dropped.
    logic                  cmd_we_q;

    logic                  m0_ready_q;
    logic                  m1_ready_q;

    logic                  gnt_valid;
    logic                  gnt_idx;

    logic                  cmd_we_d;
    logic [BE_WIDTH-1:0]   cmd_be_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_d;

    logic [DATA_WIDTH-1:0] m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_d;

    // Winner select; requests are only acted on while the FSM is in IDLE.
    tcm_rr_arb2 u_arb (
        .req_i        ({m1_if.req, m0_if.req}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    // Select the winning master's command for capture into the SRAM registers.
    always_comb begin
        cmd_we_d    = m0_if.we;
        cmd_be_d    = m0_if.be;
        cmd_addr_d  = m0_if.addr;
        cmd_wdata_d = m0_if.wdata;
        if (gnt_idx == GNT_M1) begin
            cmd_we_d    = m1_if.we;
            cmd_be_d    = m1_if.be;
            cmd_addr_d  = m1_if.addr;
            cmd_wdata_d = m1_if.wdata;
        end
    end

    // Sequencer FSM with registered SRAM command and ready pulses; last_grant
    // records the most recent winner, which drives round-robin tie-breaking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= GNT_M0;
            last_grant_q <= GNT_M1;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            cmd_we_q     <= 1'b0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
        end else begin
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q      <= ISSUE;
                        grant_q      <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        sram_en_q    <= 1'b1;
                        sram_we_q    <= cmd_we_d;
                        sram_be_q    <= cmd_be_d;
                        sram_addr_q  <= cmd_addr_d;
                        sram_wdata_q <= cmd_wdata_d;
                        cmd_we_q     <= cmd_we_d;
                    end
                end
                ISSUE: begin
                    state_q    <= WAIT;
                    sram_en_q  <= 1'b0;
                    sram_we_q  <= 1'b0;
                    m0_ready_q <= (grant_q == GNT_M0);
                    m1_ready_q <= (grant_q == GNT_M1);
                end
                WAIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    sram_en_q <= 1'b0;
                    sram_we_q <= 1'b0;
                end
            endcase
        end
    end

    // Route SRAM read data to the master being answered; zero otherwise and
    // for writes.
    always_comb begin
        m0_rdata_d = '0;
        m1_rdata_d = '0;
        if (m0_ready_q && !cmd_we_q) begin
            m0_rdata_d = sram_rdata_i;
        end
        if (m1_ready_q && !cmd_we_q) begin
            m1_rdata_d = sram_rdata_i;
        end
    end

    assign m0_if.ready  = m0_ready_q;
    assign m1_if.ready  = m1_ready_q;
    assign m0_if.rdata  = m0_rdata_d;
    assign m1_if.rdata  = m1_rdata_d;

    assign sram_en_o    = sram_en_q;
    assign sram_we_o    = sram_we_q;
    assign sram_be_o    = sram_be_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_wdata_o = sram_wdata_q;

    // The SRAM must have its data ready whenever we hand it back to a master.
    wait_sram_ready_a : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == WAIT) |-> sram_ready_i
    );

endmodule : tcm_port_arbiter
